// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types, used by the register file, ALU and control blocks.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: register 0 reads as zero.
// Build option WRITE_BYPASS_EN: a same-cycle write to the addressed register is returned directly.
module rf_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [NREGS-1:0][DATA_W-1:0]  regs_i,
    input  logic                          byp_en_i,
    input  logic [ADDR_W-1:0]             byp_addr_i,
    input  logic [DATA_W-1:0]             byp_data_i,
    output logic [DATA_W-1:0]             data_o
);

`ifdef WRITE_BYPASS_EN
    logic hit;
    assign hit = byp_en_i && (byp_addr_i == addr_i);
`else
    logic unused_byp;
    assign unused_byp = ^{byp_en_i, byp_addr_i, byp_data_i};
`endif

    always_comb begin
        data_o = '0;
        if (addr_i != '0) begin
            data_o = regs_i[addr_i];
        end
`ifdef WRITE_BYPASS_EN
        // byp_en_i is already qualified with a non-zero write address
        if (hit) begin
            data_o = byp_data_i;
        end
`endif
    end

endmodule

// File: rtl/reg_file.sv
// MIPS general-purpose register file: rs/rt/debug combinational reads, one write per clock,
// saturating count of accepted writes. Build option WRITE_BYPASS_EN enables write-before-read.
module reg_file #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
);
    import mips_pkg::*;

    localparam int NREGS_L = 2 ** ADDR_W;

    logic [NREGS_L-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           wr_accept;

    // wr_en gates the compare, so an unknown address with wr_en low cannot commit
    assign wr_accept = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (wr_accept) begin
            regs_d[wr_addr] = wr_data;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wr_count = cnt_q;

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS_L)) u_rd_rs (
        .addr_i     (rs_addr),
        .regs_i     (regs_q),
        .byp_en_i   (wr_accept),
        .byp_addr_i (wr_addr),
        .byp_data_i (wr_data),
        .data_o     (rs_data)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS_L)) u_rd_rt (
        .addr_i     (rt_addr),
        .regs_i     (regs_q),
        .byp_en_i   (wr_accept),
        .byp_addr_i (wr_addr),
        .byp_data_i (wr_data),
        .data_o     (rt_data)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS_L)) u_rd_dbg (
        .addr_i     (dbg_addr),
        .regs_i     (regs_q),
        .byp_en_i   (wr_accept),
        .byp_addr_i (wr_addr),
        .byp_data_i (wr_data),
        .data_o     (dbg_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: vector table plus reset, sweep and saturation sequences.
module tb_reg_file;

    localparam bit BYP =
`ifdef WRITE_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
    logic [31:0] rs_data, rt_data, wr_data, dbg_data;
    logic        wr_en;
    logic [15:0] wr_count;

    int n_cmp = 0;
    int n_err = 0;

    reg_file dut (
        .clk      (clk),
        .reset    (reset),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  rs, rt, dbg;
        logic [31:0] ers, ert, edbg;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Reads are checked just before the rising edge that commits the row's write.
        vecs[0] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd1, 5'd31, 32'h0, 32'h0, 32'h0, 16'd0};
        vecs[1] = '{1'b1, 5'd5, 32'h3,         5'd5, 5'd5, 5'd5,
                    BYP ? 32'h3 : 32'h0, BYP ? 32'h3 : 32'h0, BYP ? 32'h3 : 32'h0, 16'd0};
        vecs[2] = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd5, 5'd0, 32'h3, 32'h3, 32'h0, 16'd1};
        vecs[3] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 5'd0, 32'h0, 32'h3, 32'h0, 16'd1};
        vecs[4] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'd1};
        vecs[5] = '{1'b1, 5'd7, 32'h1,         5'd7, 5'd5, 5'd7,
                    BYP ? 32'h1 : 32'h0, 32'h3, BYP ? 32'h1 : 32'h0, 16'd1};
        vecs[6] = '{1'b1, 5'd7, 32'hA5A5_0000, 5'd7, 5'd7, 5'd5,
                    BYP ? 32'hA5A5_0000 : 32'h1, BYP ? 32'hA5A5_0000 : 32'h1, 32'h3, 16'd2};
        vecs[7] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd5, 5'd7, 32'hA5A5_0000, 32'h3, 32'hA5A5_0000, 16'd3};
        vecs[8] = '{1'b0, 5'bx, 32'hDEAD_BEEF, 5'd5, 5'd7, 5'd1, 32'h3, 32'hA5A5_0000, 32'h0, 16'd3};
        vecs[9] = '{1'b0, 5'd0, 32'h0,         5'd1, 5'd5, 5'd7, 32'h0, 32'h3, 32'hA5A5_0000, 16'd3};

        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rs_addr = '0; rt_addr = '0; dbg_addr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rs_addr = vecs[i].rs; rt_addr = vecs[i].rt; dbg_addr = vecs[i].dbg;
            #1;
            check($sformatf("vec%0d rs", i),  rs_data,  vecs[i].ers);
            check($sformatf("vec%0d rt", i),  rt_data,  vecs[i].ert);
            check($sformatf("vec%0d dbg", i), dbg_data, vecs[i].edbg);
            check($sformatf("vec%0d cnt", i), {16'h0, wr_count}, {16'h0, vecs[i].ecnt});
        end

        // Collision without bypass: new value visible right after the edge.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1; rs_addr = 5'd7;
        @(posedge clk); #1;
        check("collision after edge", rs_data, 32'h1);
        wr_en = 1'b0;

        // Asynchronous reset mid-run: outputs drop while reset is high.
        @(negedge clk);
        dbg_addr = 5'd5;
        #2 reset = 1'b1;
        #1 check("dbg during reset", dbg_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a); rt_addr = 5'(a); dbg_addr = 5'(a);
            #1;
            check($sformatf("post-reset rs%0d", a),  rs_data,  32'h0);
            check($sformatf("post-reset rt%0d", a),  rt_data,  32'h0);
            check($sformatf("post-reset dbg%0d", a), dbg_data, 32'h0);
        end
        check("post-reset cnt", {16'h0, wr_count}, 32'h0);

        // Fill 1..31 with i*2 and sweep the debug port.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'(a * 2);
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1 check($sformatf("sweep dbg%0d", a), dbg_data, 32'(a * 2));
        end
        check("sweep cnt", {16'h0, wr_count}, 32'd31);

        // Reset while a write to reg 9 is pending: the write is dropped.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9999_9999; dbg_addr = 5'd9;
        #2 reset = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b0;
        #1;
        check("dropped write reg9", dbg_data, 32'h0);
        check("dropped write cnt", {16'h0, wr_count}, 32'h0);

        // First write is taken on the first rising edge after release.
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; dbg_addr = 5'd3;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("first write after release", dbg_data, 32'h33);
        check("first write cnt", {16'h0, wr_count}, 32'd1);

        // Saturation of the write counter.
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h1;
        repeat (65535) @(negedge clk);
        check("cnt at 65535 writes", {16'h0, wr_count}, 32'h0000_FFFF);
        repeat (3) @(negedge clk);
        check("cnt saturated", {16'h0, wr_count}, 32'h0000_FFFF);
        wr_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
